inst_mem_server: RTL and testbench

- Responder end of the MemIntf request/response protocol: a behavioural, word-addressed memory that services a core's instruction-fetch (or data) client.
- Used as the test-harness memory behind a top-level processor's `inst_mem` client port.
- Accepts one request per cycle. Returns responses in order after a fixed, parameterised latency.
- A credit-checked response FIFO absorbs client back-pressure.

---
 rtl/inst_mem_server_pkg.sv | 28 ++
 rtl/inst_mem_server_if.sv | 30 +++
 rtl/inst_mem_server_resp_fifo.sv | 52 +++++
 rtl/inst_mem_server.sv | 132 +++++++++++++
 tb/tb_inst_mem_server.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/inst_mem_server_pkg.sv
// Shared types and constants for the inst_mem_server test-harness memory.
package inst_mem_server_pkg;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } mem_op_t;

  localparam int unsigned DEF_ADDR_BITS = 32;
  localparam int unsigned DEF_DATA_BITS = 32;
  localparam int unsigned DEF_OPAQ_BITS = 8;

  typedef struct packed {
    mem_op_t                  op;
    logic [DEF_ADDR_BITS-1:0] addr;
    logic [DEF_DATA_BITS-1:0] data;
    logic [DEF_OPAQ_BITS-1:0] opaque;
  } mem_resp_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {^(s & LFSR_TAPS), s[15:1]};
  endfunction

endpackage

// File: rtl/inst_mem_server_if.sv
// MemIntf request/response bundle; master is the client, slave is the memory.
interface inst_mem_server_if #(
  parameter int unsigned p_addr_bits = 32,
  parameter int unsigned p_data_bits = 32,
  parameter int unsigned p_opaq_bits = 8
);
  logic                     req_val;
  logic                     req_rdy;
  logic                     req_op;
  logic [p_addr_bits-1:0]   req_addr;
  logic [p_data_bits-1:0]   req_data;
  logic [p_data_bits/8-1:0] req_strb;
  logic [p_opaq_bits-1:0]   req_opaque;
  logic                     resp_val;
  logic                     resp_rdy;
  logic                     resp_op;
  logic [p_addr_bits-1:0]   resp_addr;
  logic [p_data_bits-1:0]   resp_data;
  logic [p_opaq_bits-1:0]   resp_opaque;

  modport master (
    output req_val, req_op, req_addr, req_data, req_strb, req_opaque, resp_rdy,
    input  req_rdy, resp_val, resp_op, resp_addr, resp_data, resp_opaque
  );

  modport slave (
    input  req_val, req_op, req_addr, req_data, req_strb, req_opaque, resp_rdy,
    output req_rdy, resp_val, resp_op, resp_addr, resp_data, resp_opaque
  );
endinterface

// File: rtl/inst_mem_server_resp_fifo.sv
// First-word-fall-through response FIFO; the head entry drives the response port.
module inst_mem_server_resp_fifo
  import inst_mem_server_pkg::*;
#(
  parameter int unsigned p_depth = 4,
  parameter type entry_t = mem_resp_t
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  entry_t                         push_data,
  input  logic                           pop,
  output entry_t                         head,
  output logic                           val,
  output logic [$clog2(p_depth+1)-1:0]   count
);
  localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CNT_W = $clog2(p_depth+1);

  entry_t           slots [p_depth];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(p_depth-1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  assign head = slots[rd_ptr];
  assign val  = (count != '0);

endmodule

// File: rtl/inst_mem_server.sv
// Word-addressed behavioural memory answering MemIntf requests in order after p_latency cycles.
// Optional INST_MEM_SERVER_RAND_STALL_EN adds LFSR-driven request stalls.
module inst_mem_server
  import inst_mem_server_pkg::*;
#(
  parameter int unsigned p_addr_bits  = 32,
  parameter int unsigned p_data_bits  = 32,
  parameter int unsigned p_opaq_bits  = 8,
  parameter int unsigned p_mem_words  = 1024,
  parameter int unsigned p_latency    = 2,
  parameter int unsigned p_fifo_depth = 4
) (
  input logic              clk,
  input logic              rst,
  inst_mem_server_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(p_mem_words);
  localparam int unsigned STRB_W = p_data_bits / 8;
  localparam int unsigned CRED_W = $clog2(p_fifo_depth+1);

  typedef struct packed {
    mem_op_t                op;
    logic [p_addr_bits-1:0] addr;
    logic [p_data_bits-1:0] data;
    logic [p_opaq_bits-1:0] opaque;
  } resp_t;

  logic [p_data_bits-1:0] mem [p_mem_words];
  logic [IDX_W-1:0]       idx;
  logic                   acc;
  logic                   pop;
  logic                   stall;
  logic                   rdy_q;
  logic [CRED_W-1:0]      credits;
  logic [CRED_W-1:0]      credits_nxt;
  logic [p_latency-1:0]   dl_val;
  resp_t                  dl_ent [p_latency];
  resp_t                  req_ent;
  resp_t                  fifo_head;
  logic                   fifo_val;
  logic [CRED_W-1:0]      fifo_count;

  assign idx         = bus.req_addr[2 +: IDX_W];
  assign acc         = bus.req_val && rdy_q && rst;
  assign pop         = fifo_val && bus.resp_rdy;
  assign bus.req_rdy = rdy_q;

  always_comb begin
    req_ent.op     = mem_op_t'(bus.req_op);
    req_ent.addr   = bus.req_addr;
    req_ent.opaque = bus.req_opaque;
    req_ent.data   = (req_ent.op == MEM_WRITE) ? '0 : mem[idx];
  end

  // Storage deliberately has no reset so preloads and earlier writes survive.
  always_ff @(posedge clk) begin
    if (acc && (req_ent.op == MEM_WRITE)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.req_strb[b]) mem[idx][8*b +: 8] <= bus.req_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dl_val <= '0;
    end else begin
      dl_val[0] <= acc;
      dl_ent[0] <= req_ent;
      for (int s = 1; s < p_latency; s++) begin
        dl_val[s] <= dl_val[s-1];
        dl_ent[s] <= dl_ent[s-1];
      end
    end
  end

  always_comb begin
    credits_nxt = credits;
    if (acc && !pop)      credits_nxt = credits + CRED_W'(1);
    else if (!acc && pop) credits_nxt = credits - CRED_W'(1);
  end

`ifdef INST_MEM_SERVER_RAND_STALL_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  assign lfsr_nxt = lfsr_next(lfsr);
  assign stall    = (lfsr_nxt[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= LFSR_SEED;
    else      lfsr <= lfsr_nxt;
  end
`else
  assign stall = 1'b0;
`endif

  // Ready is registered from next-cycle credits, so it always matches the credit count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      credits <= '0;
      rdy_q   <= 1'b0;
    end else begin
      credits <= credits_nxt;
      rdy_q   <= (credits_nxt < CRED_W'(p_fifo_depth)) && !stall;
    end
  end

  inst_mem_server_resp_fifo #(
    .p_depth (p_fifo_depth),
    .entry_t (resp_t)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dl_val[p_latency-1]),
    .push_data (dl_ent[p_latency-1]),
    .pop       (pop),
    .head      (fifo_head),
    .val       (fifo_val),
    .count     (fifo_count)
  );

  assign bus.resp_val    = fifo_val;
  assign bus.resp_op     = fifo_head.op;
  assign bus.resp_addr   = fifo_head.addr;
  assign bus.resp_data   = fifo_head.data;
  assign bus.resp_opaque = fifo_head.opaque;

  logic unused_bits;
  assign unused_bits = ^{bus.req_addr[1:0], bus.req_addr[p_addr_bits-1:IDX_W+2], fifo_count};

endmodule

// File: tb/tb_inst_mem_server.sv
// Self-checking bench for inst_mem_server: directed scenarios plus randomized traffic vs a transaction-level model.
module tb_inst_mem_server;
  import inst_mem_server_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int WORDS = 1024;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [7:0]  opq;
  } req_t;

  typedef struct {
    logic        op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  opq;
    int          ready;
  } exp_t;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_mem_server_if bus_if ();

  inst_mem_server #(
    .p_mem_words  (WORDS),
    .p_latency    (LAT),
    .p_fifo_depth (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  req_t        pend [$];
  exp_t        expq [$];
  logic [31:0] ref_mem [WORDS];
  logic [31:0] got_data [$];
  logic [31:0] got_addr [$];
  logic [7:0]  got_opq [$];
  int checks = 0, errors = 0, cyc = 0;
  int acc_cnt = 0, rdy_low_cnt = 0, acc_edge_last = 0, pop_cyc_last = 0;
  bit rr_rand = 0, gaps = 0;
  logic rr_fixed = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic q(input logic op, input logic [31:0] addr, input logic [31:0] data,
                   input logic [3:0] strb, input logic [7:0] opq);
    req_t r;
    r.op = op; r.addr = addr; r.data = data; r.strb = strb; r.opq = opq;
    pend.push_back(r);
  endtask

  task automatic clear_log();
    got_data.delete(); got_addr.delete(); got_opq.delete();
    acc_cnt = 0; rdy_low_cnt = 0;
  endtask

  // Transaction model: word = (addr/4) mod WORDS, response visible LAT edges after the accept edge.
  task automatic model_accept(input req_t r);
    exp_t e;
    int unsigned i;
    i = (r.addr >> 2) % WORDS;
    e.op = r.op; e.addr = r.addr; e.opq = r.opq; e.ready = cyc + 1 + LAT;
    if (r.op) begin
      for (int b = 0; b < 4; b++) if (r.strb[b]) ref_mem[i][8*b +: 8] = r.data[8*b +: 8];
      e.data = '0;
    end else begin
      e.data = ref_mem[i];
    end
    expq.push_back(e);
  endtask

  task automatic tick();
    req_t r;
    exp_t e;
    bit present;
    logic exp_v;
    present = (pend.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
    bus_if.req_val = present;
    if (present) begin
      r = pend[0];
      bus_if.req_op = r.op; bus_if.req_addr = r.addr; bus_if.req_data = r.data;
      bus_if.req_strb = r.strb; bus_if.req_opaque = r.opq;
    end else begin
      bus_if.req_op = 1'($urandom); bus_if.req_addr = $urandom; bus_if.req_data = $urandom;
      bus_if.req_strb = 4'($urandom); bus_if.req_opaque = 8'($urandom);
    end
    bus_if.resp_rdy = rr_rand ? 1'($urandom_range(0, 1)) : rr_fixed;
    #1;
    exp_v = 1'b0;
    if (expq.size() > 0) exp_v = (expq[0].ready <= cyc);
    chk("resp_val", bus_if.resp_val, exp_v);
`ifndef INST_MEM_SERVER_RAND_STALL_EN
    chk("req_rdy", bus_if.req_rdy, expq.size() < DEPTH);
`endif
    if (bus_if.resp_val && bus_if.resp_rdy && expq.size() > 0) begin
      e = expq.pop_front();
      chk("resp_op", bus_if.resp_op, e.op);
      chk("resp_addr", bus_if.resp_addr, e.addr);
      chk("resp_data", bus_if.resp_data, e.data);
      chk("resp_opaque", bus_if.resp_opaque, e.opq);
      got_data.push_back(bus_if.resp_data);
      got_addr.push_back(bus_if.resp_addr);
      got_opq.push_back(bus_if.resp_opaque);
      pop_cyc_last = cyc;
    end
    if (present && !bus_if.req_rdy) rdy_low_cnt++;
    if (present && bus_if.req_rdy) begin
      model_accept(r);
      void'(pend.pop_front());
      acc_cnt++;
      acc_edge_last = cyc + 1;
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic drain(output int n);
    n = 0;
    while ((pend.size() > 0 || expq.size() > 0) && n < 5000) begin
      tick();
      n++;
    end
    chk("drain_left", pend.size() + expq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus_if.req_val = 1'b0;
    bus_if.resp_rdy = 1'b0;
    @(posedge clk); cyc++; @(negedge clk);
    chk("rst_resp_val", bus_if.resp_val, 1'b0);
    chk("rst_req_rdy", bus_if.req_rdy, 1'b0);
    @(posedge clk); cyc++; @(negedge clk);
    expq.delete();
    pend.delete();
    rst = 1'b1;
    @(posedge clk); cyc++; @(negedge clk);
    chk("rel_req_rdy", bus_if.req_rdy, 1'b1);
    chk("rel_resp_val", bus_if.resp_val, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    rst = 1'b0;
    bus_if.req_val = 1'b0; bus_if.req_op = 1'b0; bus_if.req_addr = '0;
    bus_if.req_data = '0; bus_if.req_strb = '0; bus_if.req_opaque = '0;
    bus_if.resp_rdy = 1'b0;
    @(negedge clk);
    do_reset();

    // Preload through the write path
    q(1'b1, 32'h0,  32'hA5A5_0F0F, 4'hF, 8'h00);
    q(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 8'h01);
    q(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 8'h02);
    rr_fixed = 1'b1;
    drain(n);

    // Basic read and latency
    clear_log();
    q(1'b0, 32'h10, 32'h0, 4'h0, 8'h3C);
    drain(n);
    chk("t1_data", got_data[0], 32'hDEAD_BEEF);
    chk("t1_opaque", got_opq[0], 8'h3C);
    chk("t1_addr", got_addr[0], 32'h10);
    chk("t1_latency", pop_cyc_last - acc_edge_last, LAT);

    // Partial-strobe write followed immediately by a read of the same word
    clear_log();
    q(1'b1, 32'h20, 32'h1122_3344, 4'b0101, 8'h10);
    q(1'b0, 32'h20, 32'h0, 4'h0, 8'h11);
    drain(n);
    chk("t2_wr_data", got_data[0], 32'h0);
    chk("t2_rd_data", got_data[1], 32'hFF22_FF44);

    // Back-pressure fills the credits
    clear_log();
    rr_fixed = 1'b0;
    for (int i = 0; i < 6; i++) q(1'b0, 32'h10, 32'h0, 4'h0, 8'(i));
    repeat (8) tick();
    chk("t3_accepted", acc_cnt, 4);
    chk("t3_req_rdy", bus_if.req_rdy, 1'b0);
    rr_fixed = 1'b1;
    drain(n);
    for (int i = 0; i < 6; i++) chk("t3_order", got_opq[i], 8'(i));

    // Streaming: accept and pop every cycle
    clear_log();
    for (int i = 0; i < 20; i++) q(1'b0, 32'(i % 3) << 4, 32'h0, 4'h0, 8'(8'h40 + i));
    drain(n);
    chk("t4_cycles", n, 20 + LAT + 1);
    chk("t4_rdy_drops", rdy_low_cnt, 0);

    // Reset with requests in flight
    q(1'b1, 32'h30, 32'hCAFE_F00D, 4'hF, 8'h20);
    drain(n);
    clear_log();
    rr_fixed = 1'b0;
    for (int i = 0; i < 3; i++) q(1'b0, 32'h10, 32'h0, 4'h0, 8'(8'h50 + i));
    repeat (3) tick();
    chk("t5_inflight", acc_cnt, 3);
    do_reset();
    rr_fixed = 1'b1;
    repeat (6) tick();
    chk("t5_no_stale", got_data.size(), 0);
    q(1'b0, 32'h30, 32'h0, 4'h0, 8'h21);
    drain(n);
    chk("t5_persist", got_data[0], 32'hCAFE_F00D);

    // Address wrap and ignored low bits
    clear_log();
    q(1'b0, 32'h1000, 32'h0, 4'h0, 8'h30);
    q(1'b0, 32'h13, 32'h0, 4'h0, 8'h31);
    drain(n);
    chk("t6_wrap", got_data[0], 32'hA5A5_0F0F);
    chk("t6_lowbits", got_data[1], 32'hDEAD_BEEF);

    // Randomized traffic over a small word window
    for (int i = 0; i < 16; i++) q(1'b1, 32'(i) << 2, $urandom, 4'hF, 8'(i));
    drain(n);
    rr_rand = 1; gaps = 1;
    for (int k = 0; k < 400; k++) begin
      if (pend.size() < 3) begin
        a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        q(1'($urandom), a, $urandom, 4'($urandom), 8'($urandom));
      end
      tick();
    end
    drain(n);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
